// File: rtl/uart_tx_baud.sv
// UART transmitter: free-running 16x oversampling tick generator driving an
// LSB-first serial FSM (start bit, DBIT data bits, SB_TICK-tick stop period).
module uart_tx_baud #(
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int NB_STATE    = 2,
  parameter int BR_DIV      = 163,
  parameter int NB_BR_COUNT = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx_done_tick,
  output logic            o_tx
);

  // s must reach both 15 (start/data bits) and SB_TICK-1 (stop period)
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [NB_STATE-1:0] {IDLE, START, DATA, STOP} state_t;

  logic [NB_BR_COUNT-1:0] br_cnt_q;
  logic                   s_tick;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done;

  assign s_tick = (br_cnt_q == NB_BR_COUNT'(BR_DIV - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || s_tick) br_cnt_q <= '0;
    else                   br_cnt_q <= br_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          b_d     = i_data;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // done is Mealy: it coincides with the edge that retires the last stop tick
  assign o_tx_done_tick = done;
  assign o_tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Scoreboard bench for uart_tx_baud: stimulus queues expected frames, a
// monitor decodes the serial line and checks data, timing and done pulses.
module tb_uart_tx_baud;
  localparam int BA = 20;  // unit A: DBIT=8, SB_TICK=16
  localparam int BB = 4;   // unit B: DBIT=7, SB_TICK=32

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic       done_a, tx_a, done_b, tx_b;

  uart_tx_baud #(.DBIT(8), .SB_TICK(16), .NB_STATE(2), .BR_DIV(BA), .NB_BR_COUNT(5)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start_a), .i_data(data_a),
    .o_tx_done_tick(done_a), .o_tx(tx_a));

  uart_tx_baud #(.DBIT(7), .SB_TICK(32), .NB_STATE(2), .BR_DIV(BB), .NB_BR_COUNT(2)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start_b), .i_data(data_b),
    .o_tx_done_tick(done_b), .o_tx(tx_b));

  typedef struct {
    logic [7:0] data;
    bit         b2b;
    bit         abort;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  bit   sel = 1'b0;
  logic mon_tx, mon_done;
  int   mB, mD, mS;

  always_comb begin
    mon_tx   = sel ? tx_b : tx_a;
    mon_done = sel ? done_b : done_a;
    mB       = sel ? BB : BA;
    mD       = sel ? 7 : 8;
    mS       = sel ? 32 : 16;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint v, input longint lo, input longint hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Monitor: 0 = idle line, 1 = inside a frame, 2 = cycle after done
  initial begin : mon
    int     mst;
    longint cyc, c0, last_done, k;
    int     j, nt;
    exp_t   e;
    logic [7:0] got;
    mst = 0; cyc = 0; c0 = 0; last_done = -100; got = '0;
    e = '{data: 8'h00, b2b: 1'b0, abort: 1'b0};
    forever begin
      @(negedge clk);
      cyc++;
      nt = 16 * (1 + mD) + mS;
      case (mst)
        0: begin
          if (mon_done === 1'b1) chk("spurious_done", mon_done, 1'b0);
          if (mon_tx === 1'b0 && !rst) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_frame", sb_q.size(), 1);
              e = '{data: 8'h00, b2b: 1'b0, abort: 1'b0};
            end else begin
              e = sb_q.pop_front();
            end
            if (e.b2b) chk("b2b_gap", cyc - last_done, 3);
            c0 = cyc; got = '0; mst = 1;
          end
        end
        1: begin
          k = cyc - c0;
          if (rst) begin
            chk("rst_tx", mon_tx, 1'b1);
            chk("rst_no_done", mon_done, 1'b0);
            chk("abort_expected", e.abort, 1'b1);
            mst = 0;
          end else if (mon_done === 1'b1) begin
            chk_rng("frame_len", k, longint'(nt - 1) * mB - 1, longint'(nt) * mB - 2);
            chk("data", got, e.data);
            chk("done_tx_high", mon_tx, 1'b1);
            chk("not_aborted", e.abort, 1'b0);
            last_done = cyc; mst = 2;
          end else begin
            if (k == 8 * mB) chk("start_bit", mon_tx, 1'b0);
            if (k >= 23 * mB && (k - 23 * mB) % (16 * mB) == 0) begin
              j = int'((k - 23 * mB) / (16 * mB));
              if (j < mD) got[j] = mon_tx;
              else if (j == mD) chk("stop_bit", mon_tx, 1'b1);
            end
            if (k > longint'(nt + 2) * mB) begin
              chk("done_timeout", 0, 1);
              mst = 0;
            end
          end
        end
        2: begin
          chk("done_width", mon_done, 1'b0);
          chk("post_tx", mon_tx, 1'b1);
          mst = 0;
        end
        default: mst = 0;
      endcase
    end
  end

  task automatic push(input logic [7:0] d, input bit b2b, input bit abort);
    exp_t x;
    x = '{data: d, b2b: b2b, abort: abort};
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input logic [7:0] d);
    @(negedge clk); #1 data_a = d; start_a = 1'b1;
    @(negedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [6:0] d);
    @(negedge clk); #1 data_b = d; start_b = 1'b1;
    @(negedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int  c;
    bit  seen;
    c = 0; seen = 1'b0;
    while (!seen && c < maxc) begin
      @(negedge clk);
      c++;
      if (mon_done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin
    repeat (50) begin
      @(negedge clk);
      chk("reset_tx", tx_a, 1'b1);
      chk("reset_done", done_a, 1'b0);
    end
    #1 rst = 1'b0;
    for (int n = 1; n <= 3 * BA; n++) begin
      @(negedge clk);
      chk("tick", dut_a.s_tick, (n % BA) == BA - 1);
    end

    push(8'hAA, 1'b0, 1'b0);
    pulse_a(8'hAA);
    wait_done(4000);
    idle(5);

    // start held high: two frames back to back, data swapped after first done
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b1, 1'b0);
    @(negedge clk); #1 data_a = 8'h00; start_a = 1'b1;
    wait_done(4000);
    #1 data_a = 8'hFF;
    wait_done(4000);
    #1 start_a = 1'b0;
    idle(5);

    push(8'h55, 1'b0, 1'b0);
    pulse_a(8'h55);
    idle(16 * BA * 3);
    #1 data_a = 8'h0F;
    wait_done(4000);
    idle(5);

    push(8'h3C, 1'b0, 1'b1);
    pulse_a(8'h3C);
    idle(16 * BA * 4);
    #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    idle(20);
    push(8'hC3, 1'b0, 1'b0);
    pulse_a(8'hC3);
    wait_done(4000);
    idle(10);

    @(negedge clk); #1 sel = 1'b1;
    push(8'h5A, 1'b0, 1'b0);
    pulse_b(7'h5A);
    wait_done(1000);
    idle(5);
    push(8'h63, 1'b0, 1'b0);
    pulse_b(7'h63);
    wait_done(1000);
    idle(10);

    chk("queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
